// File: rtl/cpu_alu_ctr.sv
// Decode-stage main control and ALU control, with the ID/EX control bundle register.
// Define CPU_ALU_CTR_IMM_LOGIC_EN to decode andi/ori/slti (alu_op 11) instead of flagging them illegal.
module cpu_alu_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        bubble,
  output logic        regdst_flag,
  output logic        alusrc_flag,
  output logic        memtoreg_flag,
  output logic        regwrite_flag,
  output logic        memread_flag,
  output logic        memwrite_flag,
  output logic        branch_flag,
  output logic [1:0]  alu_op,
  output logic [3:0]  alu_cmd,
  output logic        illegal,
  output logic [3:0]  ctr_ex_q,
  output logic [2:0]  ctr_m_q,
  output logic [1:0]  ctr_wb_q,
  output logic [3:0]  alu_cmd_q
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_OR  = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_SUB = 4'b0110;
  localparam logic [3:0] CMD_SLT = 4'b0111;
  localparam logic [3:0] CMD_NOR = 4'b1100;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] funct_cmd;
  logic       funct_ok;
  logic [3:0] ctr_ex_d;
  logic [2:0] ctr_m_d;
  logic [1:0] ctr_wb_d;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  always_comb begin
    funct_cmd = CMD_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'b100000: funct_cmd = CMD_ADD;
      6'b100010: funct_cmd = CMD_SUB;
      6'b100100: funct_cmd = CMD_AND;
      6'b100101: funct_cmd = CMD_OR;
      6'b100111: funct_cmd = CMD_NOR;
      6'b101010: funct_cmd = CMD_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // The all-zero nop would otherwise decode as an R-type sll with an unsupported funct.
  always_comb begin
    regdst_flag   = 1'b0;
    alusrc_flag   = 1'b0;
    memtoreg_flag = 1'b0;
    regwrite_flag = 1'b0;
    memread_flag  = 1'b0;
    memwrite_flag = 1'b0;
    branch_flag   = 1'b0;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    if (instruction != 32'h0000_0000) begin
      case (opcode)
        OP_RTYPE: begin
          regdst_flag   = 1'b1;
          regwrite_flag = 1'b1;
          alu_op        = 2'b10;
          illegal       = ~funct_ok;
        end
        OP_LW: begin
          alusrc_flag   = 1'b1;
          memtoreg_flag = 1'b1;
          regwrite_flag = 1'b1;
          memread_flag  = 1'b1;
        end
        OP_SW: begin
          alusrc_flag   = 1'b1;
          memwrite_flag = 1'b1;
        end
        OP_BEQ: begin
          branch_flag = 1'b1;
          alu_op      = 2'b01;
        end
        OP_ADDI: begin
          alusrc_flag   = 1'b1;
          regwrite_flag = 1'b1;
        end
`ifdef CPU_ALU_CTR_IMM_LOGIC_EN
        OP_ANDI, OP_ORI, OP_SLTI: begin
          alusrc_flag   = 1'b1;
          regwrite_flag = 1'b1;
          alu_op        = 2'b11;
        end
`endif
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    alu_cmd = CMD_ADD;
    case (alu_op)
      2'b00: alu_cmd = CMD_ADD;
      2'b01: alu_cmd = CMD_SUB;
      2'b10: alu_cmd = funct_cmd;
      default: begin
`ifdef CPU_ALU_CTR_IMM_LOGIC_EN
        case (opcode)
          OP_ANDI: alu_cmd = CMD_AND;
          OP_ORI:  alu_cmd = CMD_OR;
          OP_SLTI: alu_cmd = CMD_SLT;
          default: alu_cmd = CMD_ADD;
        endcase
`else
        alu_cmd = CMD_ADD;
`endif
      end
    endcase
  end

  assign ctr_ex_d = {regdst_flag, alu_op, alusrc_flag};
  assign ctr_m_d  = {branch_flag, memread_flag, memwrite_flag};
  assign ctr_wb_d = {regwrite_flag, memtoreg_flag};

  // ID/EX boundary: reset beats bubble; both leave a nop bundle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_ex_q  <= '0;
      ctr_m_q   <= '0;
      ctr_wb_q  <= '0;
      alu_cmd_q <= '0;
    end else if (bubble) begin
      ctr_ex_q  <= '0;
      ctr_m_q   <= '0;
      ctr_wb_q  <= '0;
      alu_cmd_q <= '0;
    end else begin
      ctr_ex_q  <= ctr_ex_d;
      ctr_m_q   <= ctr_m_d;
      ctr_wb_q  <= ctr_wb_d;
      alu_cmd_q <= alu_cmd;
    end
  end

endmodule

// File: tb/tb_cpu_alu_ctr.sv
// Bench for cpu_alu_ctr: directed test-plan cases plus random instructions against a table model.
module tb_cpu_alu_ctr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        bubble;
  logic        regdst_flag, alusrc_flag, memtoreg_flag, regwrite_flag;
  logic        memread_flag, memwrite_flag, branch_flag, illegal;
  logic [1:0]  alu_op;
  logic [3:0]  alu_cmd;
  logic [3:0]  ctr_ex_q;
  logic [2:0]  ctr_m_q;
  logic [1:0]  ctr_wb_q;
  logic [3:0]  alu_cmd_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_alu_ctr dut (
    .clk(clk), .rst(rst), .instruction(instruction), .bubble(bubble),
    .regdst_flag(regdst_flag), .alusrc_flag(alusrc_flag),
    .memtoreg_flag(memtoreg_flag), .regwrite_flag(regwrite_flag),
    .memread_flag(memread_flag), .memwrite_flag(memwrite_flag),
    .branch_flag(branch_flag), .alu_op(alu_op), .alu_cmd(alu_cmd),
    .illegal(illegal), .ctr_ex_q(ctr_ex_q), .ctr_m_q(ctr_m_q),
    .ctr_wb_q(ctr_wb_q), .alu_cmd_q(alu_cmd_q)
  );

  // Expected decode: 7 flags {regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch}, alu_op, cmd, illegal.
  typedef struct packed {
    logic [6:0] flags;
    logic [1:0] aop;
    logic [3:0] cmd;
    logic       ill;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '{flags: 7'b0, aop: 2'b00, cmd: 4'd2, ill: 1'b0};
    if (ins == 32'd0) return e;
    case (op)
      6'h00: begin
        e.flags = 7'b1001000; e.aop = 2'b10;
        case (fn)
          6'h20: e.cmd = 4'd2;
          6'h22: e.cmd = 4'd6;
          6'h24: e.cmd = 4'd0;
          6'h25: e.cmd = 4'd1;
          6'h27: e.cmd = 4'd12;
          6'h2A: e.cmd = 4'd7;
          default: begin e.cmd = 4'd2; e.ill = 1'b1; end
        endcase
      end
      6'h23: e.flags = 7'b0111100;
      6'h2B: e.flags = 7'b0100010;
      6'h04: begin e.flags = 7'b0000001; e.aop = 2'b01; e.cmd = 4'd6; end
      6'h08: e.flags = 7'b0101000;
`ifdef CPU_ALU_CTR_IMM_LOGIC_EN
      6'h0C: begin e.flags = 7'b0101000; e.aop = 2'b11; e.cmd = 4'd0; end
      6'h0D: begin e.flags = 7'b0101000; e.aop = 2'b11; e.cmd = 4'd1; end
      6'h0A: begin e.flags = 7'b0101000; e.aop = 2'b11; e.cmd = 4'd7; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one decode cycle, check the combinational outputs, then the registered bundle after the edge.
  task automatic step(input logic [31:0] ins, input logic bub, input logic r);
    exp_t e;
    logic [12:0] regs_exp;
    instruction = ins;
    bubble = bub;
    rst = r;
    #1;
    e = model(ins);
    chk("flags", {25'd0, regdst_flag, alusrc_flag, memtoreg_flag, regwrite_flag,
                  memread_flag, memwrite_flag, branch_flag}, {25'd0, e.flags});
    chk("alu_op", {30'd0, alu_op}, {30'd0, e.aop});
    chk("alu_cmd", {28'd0, alu_cmd}, {28'd0, e.cmd});
    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
    if (r || bub) regs_exp = '0;
    else regs_exp = {e.flags[6], e.aop, e.flags[5], e.flags[0], e.flags[2], e.flags[1],
                     e.flags[3], e.flags[4], e.cmd};
    @(posedge clk);
    #1;
    chk("ctr_ex_q", {28'd0, ctr_ex_q}, {28'd0, regs_exp[12:9]});
    chk("ctr_m_q", {29'd0, ctr_m_q}, {29'd0, regs_exp[8:6]});
    chk("ctr_wb_q", {30'd0, ctr_wb_q}, {30'd0, regs_exp[5:4]});
    chk("alu_cmd_q", {28'd0, alu_cmd_q}, {28'd0, regs_exp[3:0]});
  endtask

  logic [5:0] ops [9]   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
  logic [5:0] fns [6]   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  initial begin
    logic [31:0] ins;
    step(32'h00851820, 1'b0, 1'b1);
    chk("reset_ex", {28'd0, ctr_ex_q}, 32'h0);
    chk("reset_cmd", {28'd0, alu_cmd_q}, 32'h0);

    step(32'h00851820, 1'b0, 1'b0);
    chk("add_ex", {28'd0, ctr_ex_q}, 32'hC);
    chk("add_wb", {30'd0, ctr_wb_q}, 32'h2);
    step(32'h8E960001, 1'b0, 1'b0);
    chk("lw_ex", {28'd0, ctr_ex_q}, 32'h1);
    chk("lw_m", {29'd0, ctr_m_q}, 32'h2);
    chk("lw_wb", {30'd0, ctr_wb_q}, 32'h3);
    step(32'h10220004, 1'b0, 1'b0);
    chk("beq_ex", {28'd0, ctr_ex_q}, 32'h2);
    chk("beq_cmd", {28'd0, alu_cmd_q}, 32'h6);
    step(32'h00851822, 1'b0, 1'b0);
    chk("sub_cmd", {28'd0, alu_cmd_q}, 32'h6);
    step(32'h0085182A, 1'b0, 1'b0);
    chk("slt_cmd", {28'd0, alu_cmd_q}, 32'h7);

    step(32'h8E960001, 1'b1, 1'b0);
    step(32'h8E960001, 1'b1, 1'b0);
    chk("bubble_hold_m", {29'd0, ctr_m_q}, 32'h0);
    step(32'h8E960001, 1'b0, 1'b0);
    chk("after_bubble_m", {29'd0, ctr_m_q}, 32'h2);
    step(32'h8E960001, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0);

    step(32'h34420005, 1'b0, 1'b0);
`ifdef CPU_ALU_CTR_IMM_LOGIC_EN
    chk("ori_cmd_q", {28'd0, alu_cmd_q}, 32'h1);
    chk("ori_ex", {28'd0, ctr_ex_q}, 32'h7);
`else
    chk("ori_ex", {28'd0, ctr_ex_q}, 32'h0);
    chk("ori_wb", {30'd0, ctr_wb_q}, 32'h0);
`endif
    instruction = 32'hFC000000;
    #1;
    chk("op3f_illegal", {31'd0, illegal}, 32'h1);
    step(32'hFC000000, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) ins[31:26] = 6'($urandom);
      if ($urandom_range(0, 19) == 0) ins = 32'd0;
      step(ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
